// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } sel_t;

  typedef enum logic [0:0] {
    IDLE,
    LU
  } state_t;

  localparam int unsigned LU_CNT_W = $clog2(8);

endpackage

// File: rtl/fwd_operand_match.sv
// Per-operand hazard match and unforced bypass select (MEM has priority over WB).
module fwd_operand_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              src_valid_i,
  input  logic [REG_AW-1:0] dest_ex_i,
  input  logic [REG_AW-1:0] dest_mem_i,
  input  logic [REG_AW-1:0] dest_wb_i,
  input  logic              wb_en_ex_i,
  input  logic              wb_en_mem_i,
  input  logic              wb_en_wb_i,
  output logic              match_ex_o,
  output logic              match_mem_o,
  output sel_t              sel_o
);

  logic match_wb;

  always_comb begin
    match_ex_o  = src_valid_i & wb_en_ex_i & (src_i == dest_ex_i);
    match_mem_o = src_valid_i & wb_en_mem_i & (src_i == dest_mem_i);
    match_wb    = src_valid_i & wb_en_wb_i & (src_i == dest_wb_i);
    if (match_mem_o) begin
      sel_o = FWD_MEM;
    end else if (match_wb) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: bypass selects, ID stall, load-use FSM, mode register
// and saturating performance counters.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fwd_mode,
  input  logic                      freeze,
  input  logic                      cnt_clr,
  input  logic [NUM_SRC*REG_AW-1:0] src,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         dest_ex,
  input  logic [REG_AW-1:0]         dest_mem,
  input  logic [REG_AW-1:0]         dest_wb,
  input  logic                      wb_en_ex,
  input  logic                      wb_en_mem,
  input  logic                      wb_en_wb,
  input  logic                      mem_r_en_ex,
  output logic [NUM_SRC*2-1:0]      sel,
  output logic                      stall,
  output logic                      fwd_mode_q,
  output logic [CNT_W-1:0]          fwd_cnt,
  output logic [CNT_W-1:0]          stall_cnt
);

  // cnt holds the number of LU cycles still to follow the current one.
  localparam int unsigned LuLoadInt = (LU_STALL > 1) ? LU_STALL - 2 : 0;
  localparam logic [LU_CNT_W-1:0] LuLoad = LU_CNT_W'(LuLoadInt);

  logic [NUM_SRC-1:0] match_ex;
  logic [NUM_SRC-1:0] match_mem;
  sel_t               sel_raw [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_op
    fwd_operand_match #(
      .REG_AW(REG_AW)
    ) u_match (
      .src_i      (src[g*REG_AW +: REG_AW]),
      .src_valid_i(src_valid[g]),
      .dest_ex_i  (dest_ex),
      .dest_mem_i (dest_mem),
      .dest_wb_i  (dest_wb),
      .wb_en_ex_i (wb_en_ex),
      .wb_en_mem_i(wb_en_mem),
      .wb_en_wb_i (wb_en_wb),
      .match_ex_o (match_ex[g]),
      .match_mem_o(match_mem[g]),
      .sel_o      (sel_raw[g])
    );
  end

  state_t              state_q, state_d;
  logic [LU_CNT_W-1:0] cnt_q, cnt_d;
  logic                fwd_mode_d;
  logic [CNT_W-1:0]    fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                lu_hit;
  logic [2:0]          fwd_inc;
  logic [CNT_W+2:0]    fwd_sum;
  sel_t                op_sel;

  always_comb begin
    lu_hit = fwd_mode_q & mem_r_en_ex & (|match_ex);
    if (state_q == LU) begin
      stall = 1'b1;
    end else if (fwd_mode_q) begin
      stall = lu_hit;
    end else begin
      stall = |(match_ex | match_mem);
    end
  end

  always_comb begin
    sel     = '0;
    fwd_inc = '0;
    op_sel  = FWD_RF;
    for (int i = 0; i < NUM_SRC; i++) begin
      op_sel = (fwd_mode_q && !stall) ? sel_raw[i] : FWD_RF;
      sel[i*2 +: 2] = op_sel;
      if (op_sel != FWD_RF) begin
        fwd_inc = fwd_inc + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (lu_hit) begin
            cnt_d = LuLoad;
            if (LU_STALL > 1) begin
              state_d = LU;
            end
          end
        end
        LU: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LU_CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fwd_mode_d = (!stall && !freeze) ? fwd_mode : fwd_mode_q;
  end

  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    fwd_sum     = {3'b000, fwd_cnt_q} + {{CNT_W{1'b0}}, fwd_inc};
    if (!freeze) begin
      if (cnt_clr) begin
        fwd_cnt_d   = '0;
        stall_cnt_d = '0;
      end else begin
        fwd_cnt_d = (fwd_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fwd_mode_q  <= 1'b0;
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fwd_mode_q  <= fwd_mode_d;
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
